// File: rtl/pe_normalize_acc.sv
// pe_normalize_acc: turns the adder-tree sum into a sign/exponent/RNE-rounded
// mantissa and holds the accumulator fed back to the adder tree.
module pe_normalize_acc #(
    parameter int SUM_W    = 66,
    parameter int EXP_W    = 13,
    parameter int MAN_W    = 52,
    parameter int FRAC_POS = 62,
    parameter int EMAX     = 1023,
    parameter int EMIN     = -1022
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SUM_W-1:0]        sum_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic                    acc_en,
    input  logic                    acc_clr,
    output logic [SUM_W-1:0]        acc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_W-1:0]        out_exp,
    output logic [MAN_W-1:0]        out_man,
    output logic                    out_zero,
    output logic                    out_ovf,
    output logic                    out_unf
);

    localparam int LZW   = $clog2(SUM_W + 1);
    localparam int XW    = EXP_W + 1;
    localparam int G_POS = SUM_W - 2 - MAN_W;

    localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
    localparam logic signed [XW-1:0] EMIN_X = XW'(EMIN);
    localparam logic [XW-1:0]        P_OFS  = XW'(SUM_W - 1 - FRAC_POS);

    function automatic logic [LZW-1:0] lzc_f(input logic [SUM_W-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = LZW'(SUM_W);
        found = 1'b0;
        for (int i = SUM_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZW'(SUM_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic stall;
    logic adv;
    logic accept;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;
    assign accept   = in_valid & in_ready;

    // Input capture rank keeps adder-tree timing off the negate/LZC path.
    logic                    v0;
    logic [SUM_W-1:0]        sum0;
    logic signed [EXP_W-1:0] exp0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0   <= 1'b0;
            sum0 <= '0;
            exp0 <= '0;
        end else if (adv) begin
            v0 <= in_valid;
            if (in_valid) begin
                sum0 <= sum_in;
                exp0 <= exp_in;
            end
        end
    end

    // S1: sign and magnitude; -2^(SUM_W-1) maps to itself as unsigned.
    logic             sign_c;
    logic [SUM_W-1:0] mag_c;

    assign sign_c = sum0[SUM_W-1];
    assign mag_c  = sign_c ? -sum0 : sum0;

    logic                    v1;
    logic                    sign1;
    logic [SUM_W-1:0]        mag1;
    logic signed [EXP_W-1:0] exp1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            mag1  <= '0;
            exp1  <= '0;
        end else if (adv) begin
            v1 <= v0;
            if (v0) begin
                sign1 <= sign_c;
                mag1  <= mag_c;
                exp1  <= exp0;
            end
        end
    end

    // S2: normalize so the leading one sits in the MSB.
    logic [LZW-1:0]       lzc_c;
    logic [SUM_W-1:0]     norm_c;
    logic signed [XW-1:0] exp_pre_c;

    always_comb begin
        lzc_c     = lzc_f(mag1);
        norm_c    = mag1 << lzc_c;
        exp_pre_c = {exp1[EXP_W-1], exp1} + P_OFS - XW'(lzc_c);
    end

    logic                 v2;
    logic                 sign2;
    logic [SUM_W-1:0]     norm2;
    logic signed [XW-1:0] exp2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            norm2 <= '0;
            exp2  <= '0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                sign2 <= sign1;
                norm2 <= norm_c;
                exp2  <= exp_pre_c;
            end
        end
    end

    // S3: round to nearest even; a zero MSB after normalizing means zero.
    logic [MAN_W-1:0]     man_t;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [MAN_W:0]       man_inc;
    logic signed [XW-1:0] exp_fin;
    logic                 nonzero;

    always_comb begin
        man_t    = norm2[SUM_W-2 -: MAN_W];
        guard    = norm2[G_POS];
        sticky   = |norm2[G_POS-1:0];
        round_up = guard & (sticky | man_t[0]);
        man_inc  = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
        exp_fin  = exp2 + {{(XW-1){1'b0}}, man_inc[MAN_W]};
        nonzero  = norm2[SUM_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_man   <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                out_zero <= ~nonzero;
                if (nonzero) begin
                    out_sign <= sign2;
                    out_exp  <= exp_fin[EXP_W-1:0];
                    out_man  <= man_inc[MAN_W-1:0];
                    out_ovf  <= exp_fin > EMAX_X;
                    out_unf  <= exp_fin < EMIN_X;
                end else begin
                    out_sign <= 1'b0;
                    out_exp  <= '0;
                    out_man  <= '0;
                    out_ovf  <= 1'b0;
                    out_unf  <= 1'b0;
                end
            end
        end
    end

    // Clear wins over load and ignores the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out <= '0;
        end else if (acc_clr) begin
            acc_out <= '0;
        end else if (accept && acc_en) begin
            acc_out <= sum_in;
        end
    end

endmodule

// File: tb/tb_pe_normalize_acc.sv
// tb_pe_normalize_acc: random and directed beats scored against an
// arithmetic reference model through an expected-result queue.
module tb_pe_normalize_acc;

    localparam int SUM_W = 66;
    localparam int EXP_W = 13;
    localparam int MAN_W = 52;
    localparam int RW    = 1 + EXP_W + MAN_W + 3;

    typedef logic [SUM_W:0] wide_t;

    localparam logic [SUM_W-1:0] ONE = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_in;
    logic [EXP_W-1:0] exp_in;
    logic             acc_en;
    logic             acc_clr;
    logic [SUM_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic             out_zero;
    logic             out_ovf;
    logic             out_unf;

    pe_normalize_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .exp_in    (exp_in),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_man   (out_man),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    logic [RW-1:0]    dut_res;
    logic [RW-1:0]    exp_q[$];
    logic [SUM_W-1:0] acc_m;
    int               n_total = 0;
    int               n_pass = 0;
    int               ready_mode = 0;
    int               stall_cycles = 0;

    assign dut_res = {out_sign, out_exp, out_man, out_zero, out_ovf, out_unf};

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    function automatic logic [RW-1:0] pack_exp(input bit sg, input int ee,
                                               input logic [MAN_W-1:0] mm,
                                               input bit z);
        return {sg, EXP_W'(ee), mm, z, ee > 1023, (!z) && (ee < -1022)};
    endfunction

    // Value = sum * 2^(exp - 62); round magnitude to 53 significant bits.
    function automatic logic [RW-1:0] model(input logic [SUM_W-1:0] s,
                                            input logic [EXP_W-1:0] e);
        wide_t mag, q, rem, half;
        int    p, sh, ee;
        mag = s[SUM_W-1] ? ((wide_t'(1) << SUM_W) - {1'b0, s}) : {1'b0, s};
        if (mag == '0) return pack_exp(0, 0, '0, 1);
        p = 0;
        for (int i = 0; i <= SUM_W; i++) if (mag[i]) p = i;
        ee = $signed(e) + p - 62;
        sh = p - MAN_W;
        if (sh <= 0) begin
            q = mag << (-sh);
        end else begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = wide_t'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + wide_t'(1);
        end
        if (q == (wide_t'(1) << (MAN_W + 1))) begin
            q  = wide_t'(1) << MAN_W;
            ee = ee + 1;
        end
        return pack_exp(s[SUM_W-1], ee, MAN_W'(q - (wide_t'(1) << MAN_W)), 0);
    endfunction

    function automatic logic [SUM_W-1:0] rnd_sum();
        logic [SUM_W-1:0] v;
        int               k;
        v = SUM_W'({$urandom, $urandom, $urandom});
        case ($urandom_range(0, 7))
            0: v = v;
            1: v = v >> $urandom_range(0, SUM_W - 1);
            2: v = -(v >> $urandom_range(1, SUM_W - 1));
            3: v = ONE << $urandom_range(0, SUM_W - 1);
            4: begin
                k = $urandom_range(MAN_W + 1, SUM_W - 2);
                v = (ONE << k) | (ONE << (k - MAN_W - 1));
                if ($urandom_range(0, 1) != 0) v = v | (ONE << (k - MAN_W));
                if ($urandom_range(0, 1) != 0) v = -v;
            end
            5: v = '0;
            6: v = ONE << (SUM_W - 1);
            default: v = {SUM_W{1'b1}} >> $urandom_range(0, SUM_W - 1);
        endcase
        return v;
    endfunction

    function automatic logic [EXP_W-1:0] rnd_exp();
        if ($urandom_range(0, 3) == 0) return EXP_W'($urandom);
        return EXP_W'($urandom_range(0, 60) - 30);
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [SUM_W-1:0] s, input logic [EXP_W-1:0] e,
                        input bit ae, input bit clr, input logic [RW-1:0] want);
        int waited;
        in_valid = 1'b1;
        sum_in   = s;
        exp_in   = e;
        acc_en   = ae;
        acc_clr  = clr;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("accept", in_ready, 1);
        if (in_ready) exp_q.push_back(want);
        if (clr) acc_m = '0;
        else if (ae && in_ready) acc_m = s;
        @(posedge clk);
        #1;
        check("acc_out", acc_out, acc_m);
        in_valid = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        do begin
            @(posedge clk);
            w++;
        end while (exp_q.size() != 0 && w < 500);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic send_rnd(input bit ae, input bit clr);
        logic [SUM_W-1:0] s;
        logic [EXP_W-1:0] e;
        s = rnd_sum();
        e = rnd_exp();
        send(s, e, ae, clr, model(s, e));
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    logic [RW-1:0] held;
    bit            hold_pend = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (!in_ready) stall_cycles++;
            if (hold_pend) check("hold", {out_valid, dut_res}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_output: got %h, want no output", dut_res);
                end else begin
                    check("result", dut_res, exp_q.pop_front());
                end
            end
            hold_pend = out_valid && !out_ready;
            held      = dut_res;
        end
    end

    initial begin
        int               lat;
        int               st0;
        logic [SUM_W-1:0] t;
        logic [SUM_W-1:0] pat;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        sum_in   = '0;
        exp_in   = '0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        acc_m    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", dut_res, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_acc", acc_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(ONE << 62, '0, 0, 0, pack_exp(0, 0, '0, 0));
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        check("latency", lat, 3);

        t = SUM_W'(3) << 61;
        send(-t, EXP_W'(5), 0, 0, pack_exp(1, 5, ONE[MAN_W-1:0] << 51, 0));
        send(ONE, '0, 0, 0, pack_exp(0, -62, '0, 0));
        send('0, EXP_W'(77), 0, 0, pack_exp(0, 0, '0, 1));
        send((ONE << 65) - ONE, '0, 0, 0, pack_exp(0, 3, '0, 0));
        send((ONE << 62) | (ONE << 9), '0, 0, 0, pack_exp(0, 0, '0, 0));
        send((ONE << 62) | (ONE << 10) | (ONE << 9), '0, 0, 0,
             pack_exp(0, 0, MAN_W'(2), 0));
        send(ONE << 65, '0, 0, 0, pack_exp(1, 3, '0, 0));
        send(ONE << 62, EXP_W'(1023), 0, 0, pack_exp(0, 1023, '0, 0));
        send(ONE << 62, EXP_W'(1024), 0, 0, pack_exp(0, 1024, '0, 0));
        send(ONE << 62, EXP_W'(-1022), 0, 0, pack_exp(0, -1022, '0, 0));
        send(ONE << 62, EXP_W'(-1023), 0, 0, pack_exp(0, -1023, '0, 0));
        send((ONE << 65) - ONE, EXP_W'(1020), 0, 0, pack_exp(0, 1023, '0, 0));
        send((ONE << 65) - ONE, EXP_W'(1021), 0, 0, pack_exp(0, 1024, '0, 0));
        drain();

        pat = {33{2'b01}};
        send(pat, '0, 1, 0, model(pat, '0));
        send_rnd(0, 0);
        send_rnd(1, 1);
        send(pat, '0, 1, 0, model(pat, '0));
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_m = '0;
        check("acc_clr_idle", acc_out, acc_m);
        acc_clr = 1'b0;
        drain();

        st0 = stall_cycles;
        fork
            for (int i = 0; i < 8; i++) send_rnd(0, 0);
            begin
                repeat (4) @(posedge clk);
                #1 ready_mode = 2;
                repeat (4) @(posedge clk);
                #1 ready_mode = 0;
            end
        join
        drain();
        check("stall_cycles", stall_cycles - st0, 4);

        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send_rnd($urandom_range(0, 1), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        ready_mode = 0;
        for (int i = 0; i < 4; i++) send_rnd(1, 0);
        ready_mode = 2;
        @(posedge clk);
        #1;
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_result", dut_res, 0);
        check("async_acc", acc_out, 0);
        check("async_in_ready", in_ready, 1);
        exp_q.delete();
        acc_m      = '0;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) send_rnd($urandom_range(0, 1), 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
